// File: rtl/gecko_print_pkg.sv
// Shared types and constants for the gecko print UART transmitter.
// Pure declarations; no logic, no latency, no flow control.
package gecko_print_pkg;

    localparam int UART_DATA_BITS = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_tx_state_t;

endpackage

// File: rtl/gecko_print_fifo.sv
// Byte FIFO, registered count, head read combinationally (0-cycle pop data).
// Push refused when full even if a pop occurs in the same cycle; pop ignored when empty.
module gecko_print_fifo
    import gecko_print_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      push_vld,
    output logic                      push_rdy,
    input  logic [UART_DATA_BITS-1:0] push_dat,
    input  logic                      pop_en,
    output logic [UART_DATA_BITS-1:0] pop_dat,
    output logic [CNT_W-1:0]          count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W-1:0] PTR_ONE = 1;
    localparam logic [CNT_W-1:0] CNT_ONE = 1;
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    logic [UART_DATA_BITS-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]          wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]          rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]          count_q, count_d;
    logic                      push_fire;
    logic                      pop_fire;

    // Full/empty come from the count so pointers may wrap freely.
    assign push_rdy  = (count_q != CNT_FULL) && rst;
    assign push_fire = push_vld && push_rdy;
    assign pop_fire  = pop_en && (count_q != '0);
    assign pop_dat   = mem_q[rd_ptr_q];
    assign count     = count_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_fire) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (pop_fire) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
        case ({push_fire, pop_fire})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_fire) begin
            mem_q[wr_ptr_q] <= push_dat;
        end
    end

endmodule

// File: rtl/gecko_print_uart_tx.sv
// Print stream to 8N1 UART TX, LSB first; tx falls the cycle after the pop, frame 10*CLKS_PER_BIT.
// Backpressure: print_ready low only when the input FIFO is full or in reset.
module gecko_print_uart_tx
    import gecko_print_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868,
    parameter int FIFO_DEPTH   = 16,
    parameter int COUNT_WIDTH  = $clog2(FIFO_DEPTH + 1)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      print_valid,
    output logic                      print_ready,
    input  logic [UART_DATA_BITS-1:0] print_data,
    output logic                      uart_tx,
    output logic                      busy,
    output logic [COUNT_WIDTH-1:0]    fifo_count
);

    localparam int BAUD_W = $clog2(CLKS_PER_BIT);
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BAUD_W-1:0] BAUD_ONE  = 1;
    localparam logic [2:0]        BIT_LAST  = 3'(UART_DATA_BITS - 1);

    if (CLKS_PER_BIT < 2) begin : g_bad_clks_per_bit
        $error("gecko_print_uart_tx: CLKS_PER_BIT must be >= 2");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_fifo_depth
        $error("gecko_print_uart_tx: FIFO_DEPTH must be a power of 2, >= 2");
    end

    uart_tx_state_t            state_q, state_d;
    logic [BAUD_W-1:0]         baud_q, baud_d;
    logic [2:0]                bit_q, bit_d;
    logic [UART_DATA_BITS-1:0] shift_q, shift_d;
    logic                      tx_q, tx_d;

    logic                      pop_en;
    logic [UART_DATA_BITS-1:0] head_dat;
    logic                      fifo_empty;
    logic                      baud_last;

    gecko_print_fifo #(
        .DEPTH (FIFO_DEPTH),
        .CNT_W (COUNT_WIDTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push_vld (print_valid),
        .push_rdy (print_ready),
        .push_dat (print_data),
        .pop_en   (pop_en),
        .pop_dat  (head_dat),
        .count    (fifo_count)
    );

    assign fifo_empty = (fifo_count == '0);
    assign baud_last  = (baud_q == BAUD_LAST);
    assign uart_tx    = tx_q;
    assign busy       = (state_q != IDLE) || !fifo_empty;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
        end
    end

    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        pop_en  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    pop_en  = 1'b1;
                    shift_d = head_dat;
                    baud_d  = '0;
                    state_d = START;
                end
            end
            START: begin
                if (baud_last) begin
                    baud_d  = '0;
                    bit_d   = '0;
                    state_d = DATA;
                end else begin
                    baud_d = baud_q + BAUD_ONE;
                end
            end
            DATA: begin
                if (baud_last) begin
                    baud_d  = '0;
                    shift_d = shift_q >> 1;
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == BIT_LAST) begin
                        state_d = STOP;
                    end
                end else begin
                    baud_d = baud_q + BAUD_ONE;
                end
            end
            STOP: begin
                if (baud_last) begin
                    baud_d = '0;
                    // Chain straight into the next start bit when data is waiting.
                    if (!fifo_empty) begin
                        pop_en  = 1'b1;
                        shift_d = head_dat;
                        state_d = START;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    baud_d = baud_q + BAUD_ONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Line level follows the state being entered, so tx_q lines up with state_q.
    always_comb begin
        tx_d = 1'b1;
        unique case (state_d)
            IDLE:    tx_d = 1'b1;
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift_d[0];
            STOP:    tx_d = 1'b1;
            default: tx_d = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_gecko_print_uart_tx.sv
// Directed bench for gecko_print_uart_tx at CLKS_PER_BIT=4, FIFO_DEPTH=4.
// A background decoder rebuilds bytes from the serial line for order checks.
module tb_gecko_print_uart_tx;

    localparam int CPB   = 4;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH + 1);

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          print_valid = 1'b0;
    logic          print_ready;
    logic [7:0]    print_data = 8'h00;
    logic          uart_tx;
    logic          busy;
    logic [CW-1:0] fifo_count;

    int checks = 0;
    int errors = 0;
    logic mon_en = 1'b0;
    logic [7:0] rx_q [$];

    gecko_print_uart_tx #(
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .print_valid (print_valid),
        .print_ready (print_ready),
        .print_data  (print_data),
        .uart_tx     (uart_tx),
        .busy        (busy),
        .fifo_count  (fifo_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_byte(input logic [7:0] b);
        int n;
        n = 0;
        print_valid = 1'b1;
        print_data  = b;
        while (!print_ready && n < 400) begin
            tick();
            n++;
        end
        check("push_ready", print_ready, 1);
        tick();
        print_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy && n < 3000) begin
            tick();
            n++;
        end
        check("idle_reached", busy, 0);
    endtask

    // Expected line level j cycles after the pop edge of a frame carrying b.
    function automatic logic exp_bit(input logic [7:0] b, input int j);
        if (j < CPB) return 1'b0;
        if (j >= 9 * CPB) return 1'b1;
        return b[(j / CPB) - 1];
    endfunction

    initial begin
        logic [7:0] b;
        forever begin
            @(posedge clk);
            #2;
            if (mon_en && rst && uart_tx === 1'b0) begin
                repeat (CPB / 2) @(posedge clk);
                #2;
                check("mon_start_bit", uart_tx, 0);
                for (int i = 0; i < 8; i++) begin
                    repeat (CPB) @(posedge clk);
                    #2;
                    b[i] = uart_tx;
                end
                repeat (CPB) @(posedge clk);
                #2;
                check("mon_stop_bit", uart_tx, 1);
                rx_q.push_back(b);
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] bb [3];
        logic [7:0] full_b [6];
        int n;

        // Reset with valid held high: nothing accepted, line idle.
        rst = 1'b0;
        print_valid = 1'b1;
        print_data = 8'h99;
        repeat (5) tick();
        check("rst_ready", print_ready, 0);
        check("rst_tx", uart_tx, 1);
        check("rst_busy", busy, 0);
        check("rst_count", fifo_count, 0);
        print_valid = 1'b0;
        rst = 1'b1;
        tick();
        check("post_rst_count", fifo_count, 0);
        check("post_rst_busy", busy, 0);
        check("post_rst_ready", print_ready, 1);

        // Single byte 0x55: per-cycle waveform over the 40-cycle frame.
        mon_en = 1'b1;
        rx_q.delete();
        print_valid = 1'b1;
        print_data = 8'h55;
        tick();
        print_valid = 1'b0;
        check("single_count_e0", fifo_count, 1);
        check("single_tx_e0", uart_tx, 1);
        tick();
        check("single_tx_j0", uart_tx, 0);
        check("single_count_j0", fifo_count, 0);
        check("single_busy_j0", busy, 1);
        for (int j = 1; j < 10 * CPB; j++) begin
            tick();
            check($sformatf("single_tx_j%0d", j), uart_tx, exp_bit(8'h55, j));
        end
        check("single_busy_last", busy, 1);
        tick();
        check("single_busy_end", busy, 0);
        check("single_tx_end", uart_tx, 1);
        check("single_rx_len", rx_q.size(), 1);
        if (rx_q.size() > 0) check("single_rx_byte", rx_q[0], 8'h55);

        // Back-to-back 0x41,0x42,0x43: 120 cycles with no idle gap.
        rx_q.delete();
        bb = '{8'h41, 8'h42, 8'h43};
        push_byte(bb[0]);
        push_byte(bb[1]);
        push_byte(bb[2]);
        check("b2b_count_j1", fifo_count, 2);
        check("b2b_tx_j1", uart_tx, exp_bit(bb[0], 1));
        for (int j = 2; j < 30 * CPB; j++) begin
            tick();
            check($sformatf("b2b_tx_j%0d", j), uart_tx, exp_bit(bb[j / (10 * CPB)], j % (10 * CPB)));
        end
        tick();
        check("b2b_busy_end", busy, 0);
        check("b2b_rx_len", rx_q.size(), 3);
        for (int i = 0; i < rx_q.size() && i < 3; i++) check($sformatf("b2b_rx_%0d", i), rx_q[i], bb[i]);

        // Full FIFO: 6 bytes, 4 queued plus 1 in flight, ready returns after stop-bit pop.
        rx_q.delete();
        full_b = '{8'h10, 8'h21, 8'h32, 8'h43, 8'h54, 8'h65};
        for (int i = 0; i < 5; i++) push_byte(full_b[i]);
        check("full_count", fifo_count, 4);
        check("full_ready", print_ready, 0);
        print_valid = 1'b1;
        print_data = full_b[5];
        n = 0;
        while (!print_ready && n < 100) begin
            tick();
            n++;
        end
        check("full_ready_reassert_cycles", n, 37);
        check("full_count_after_pop", fifo_count, 3);
        push_byte(full_b[5]);
        check("full_count_refill", fifo_count, 4);
        wait_idle();
        check("full_rx_len", rx_q.size(), 6);
        for (int i = 0; i < rx_q.size() && i < 6; i++) check($sformatf("full_rx_%0d", i), rx_q[i], full_b[i]);

        // Pointer wrap: 40 sequential bytes through the 4-deep FIFO.
        rx_q.delete();
        for (int i = 0; i < 40; i++) push_byte(8'(i));
        wait_idle();
        check("wrap_rx_len", rx_q.size(), 40);
        for (int i = 0; i < rx_q.size() && i < 40; i++) check($sformatf("wrap_rx_%0d", i), rx_q[i], 8'(i));

        // Mid-frame reset during data bit 3 of 0xA5 with two bytes queued.
        mon_en = 1'b0;
        push_byte(8'hA5);
        push_byte(8'h11);
        push_byte(8'h22);
        repeat (16) tick();
        check("midrst_tx_bit3", uart_tx, 0);
        check("midrst_count_before", fifo_count, 2);
        rst = 1'b0;
        tick();
        check("midrst_tx", uart_tx, 1);
        check("midrst_count", fifo_count, 0);
        check("midrst_busy", busy, 0);
        check("midrst_ready", print_ready, 0);
        rst = 1'b1;
        for (int j = 0; j < 60; j++) begin
            tick();
            check($sformatf("midrst_quiet_tx_%0d", j), uart_tx, 1);
        end
        check("midrst_quiet_busy", busy, 0);
        check("midrst_quiet_count", fifo_count, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
